// File: rtl/axis_pkg.sv
// axis_pkg: shared count-width helper and default beat layout for the AXI-Stream FIFO.
package axis_pkg;
   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_USER_WIDTH = 1;
   typedef struct packed {
      logic [DEF_DATA_WIDTH-1:0]   tdata;
      logic [DEF_DATA_WIDTH/8-1:0] tkeep;
      logic                        tlast;
      logic [DEF_USER_WIDTH-1:0]   tuser;
   } axis_beat_t;
   function automatic int clog2_cnt(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/axis_sdp_ram.sv
// axis_sdp_ram: simple dual-port array, synchronous write and asynchronous read (distributed RAM).
module axis_sdp_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: single-clock first-word-fall-through AXI4-Stream FIFO with optional
// store-and-forward gating that releases a frame only once its tlast beat is buffered.
module axis_pkt_fifo import axis_pkg::*; #(
   parameter int DATA_WIDTH  = 64,
   parameter int USER_WIDTH  = 1,
   parameter int DEPTH       = 16,
   parameter int PACKET_MODE = 0
) (
   input  logic                           s_axis_aclk,
   input  logic                           s_axis_aresetn,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]        s_axis_tkeep,
   input  logic                           s_axis_tlast,
   input  logic [USER_WIDTH-1:0]          s_axis_tuser,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic [DATA_WIDTH-1:0]          m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]        m_axis_tkeep,
   output logic                           m_axis_tlast,
   output logic [USER_WIDTH-1:0]          m_axis_tuser,
   output logic [clog2_cnt(DEPTH)-1:0]    axis_data_count,
   output logic [clog2_cnt(DEPTH)-1:0]    axis_pkt_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = clog2_cnt(DEPTH);
   typedef struct packed {
      logic [DATA_WIDTH-1:0]   tdata;
      logic [DATA_WIDTH/8-1:0] tkeep;
      logic                    tlast;
      logic [USER_WIDTH-1:0]   tuser;
   } beat_t;
   beat_t         wr_beat, rd_beat;
   logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] data_cnt_q, data_cnt_d, pkt_cnt_q, pkt_cnt_d;
   logic          oor_q, oor_d, full, wr_en, rd_en;
   assign wr_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};
   // Full when the pointers differ only in the wrap bit; everything here depends on flops only.
   always_comb begin
      full          = (wr_ptr_q ^ rd_ptr_q) == CW'(DEPTH);
      s_axis_tready = oor_q && !full;
      m_axis_tvalid = (data_cnt_q != '0) && (PACKET_MODE == 0 || pkt_cnt_q != '0 || full);
      wr_en         = s_axis_tvalid && s_axis_tready;
      rd_en         = m_axis_tvalid && m_axis_tready;
      wr_ptr_d      = wr_ptr_q + CW'(wr_en);
      rd_ptr_d      = rd_ptr_q + CW'(rd_en);
      data_cnt_d    = data_cnt_q + CW'(wr_en) - CW'(rd_en);
      pkt_cnt_d     = pkt_cnt_q + CW'(wr_en && s_axis_tlast) - CW'(rd_en && rd_beat.tlast);
      oor_d         = 1'b1;
   end
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         data_cnt_q <= '0;
         pkt_cnt_q  <= '0;
         oor_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         data_cnt_q <= data_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         oor_q      <= oor_d;
      end
   end
   axis_sdp_ram #(.WIDTH($bits(beat_t)), .DEPTH(DEPTH)) u_ram (
      .clk   (s_axis_aclk),
      .we    (wr_en),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (wr_beat),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (rd_beat)
   );
   assign m_axis_tdata    = rd_beat.tdata;
   assign m_axis_tkeep    = rd_beat.tkeep;
   assign m_axis_tlast    = rd_beat.tlast;
   assign m_axis_tuser    = rd_beat.tuser;
   assign axis_data_count = data_cnt_q;
   assign axis_pkt_count  = pkt_cnt_q;
endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Parametrised single-clock AXI4-Stream FIFO replacing the fixed 64-bit `axis_data_fifo_0` stand-in on the nfsume 10G datapath. Width, depth and tuser width are configurable. Output is first-word-fall-through. An optional packet mode holds `m_axis_tvalid` low until a whole frame (tlast written) is buffered. It sits between the MAC RX stream and the mitikv filter/forwarding logic, giving real back-pressure and occupancy instead of a fixed pipeline delay.

## Interface

Parameters:
- DATA_WIDTH, default 64: tdata width in bits; multiple of 8; tkeep width is DATA_WIDTH/8.
- USER_WIDTH, default 1: tuser width in bits.
- DEPTH, default 16: number of entries; power of two, at least 4.
- PACKET_MODE, default 0: 1 enables store-and-forward gating.

Ports:
- s_axis_aclk  in  1  the only clock.
- s_axis_aresetn  in  1  reset, asynchronous assert, active-low.
- s_axis_tvalid, s_axis_tready  in/out  1  slave handshake.
- s_axis_tdata  in  DATA_WIDTH  slave data.
- s_axis_tkeep  in  DATA_WIDTH/8  slave byte enables.
- s_axis_tlast  in  1  slave end of packet.
- s_axis_tuser  in  USER_WIDTH  slave user bits.
- m_axis_tvalid, m_axis_tready  out/in  1  master handshake.
- m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser  out  same widths as the slave side  head-of-FIFO beat.
- axis_data_count  out  $clog2(DEPTH)+1  number of stored beats.
- axis_pkt_count  out  $clog2(DEPTH)+1  number of stored beats with tlast set.

## Operation

- Write: when `s_axis_tvalid && s_axis_tready`, store the beat {tdata, tkeep, tlast, tuser} at wr_ptr, then increment wr_ptr. Pointers are $clog2(DEPTH)+1 bits and wrap naturally; the MSB distinguishes full from empty.
- Read: when `m_axis_tvalid && m_axis_tready`, increment rd_ptr.
- `axis_data_count`:
  - +1 on write only, -1 on read only, unchanged when both happen in the same cycle.
  - Range 0..DEPTH; never wraps.
- `axis_pkt_count`:
  - +1 on a write with tlast, -1 on a read with tlast.
  - Simultaneous events net out, as for the data count.
- `s_axis_tready` = `!full && out_of_reset`:
  - full means data count == DEPTH.
  - Simultaneous read and write at full is not possible, because tready is low.
- `m_axis_tvalid`:
  - PACKET_MODE=0: data count != 0.
  - PACKET_MODE=1: data count != 0 && (pkt count != 0 || full). The full override prevents deadlock on frames longer than DEPTH; those frames degrade to cut-through.
- Master data outputs always show the entry at rd_ptr. They are don't-care while tvalid is low, but must be stable while tvalid is high and tready is low.
- No data loss or reordering. tkeep and tuser pass through unmodified.

## Timing

- Reset (asserted asynchronously):
  - Pointers, counts, `m_axis_tvalid` and `s_axis_tready` all go to 0.
  - The data array is not reset.
  - Frames that were in flight are discarded.
- `out_of_reset` is a flop that rises on the first clock edge after reset deasserts. `s_axis_tready` therefore goes high 1 cycle after release.
- Write-to-read latency, PACKET_MODE=0: a beat accepted at edge N gives `m_axis_tvalid`=1 after edge N, so it is readable in cycle N+1.
- Write-to-read latency, PACKET_MODE=1: the tlast beat accepted at edge N releases the frame in cycle N+1.
- Full release: a read at edge N raises `s_axis_tready` after edge N, with no extra bubble. Sustained throughput is 1 beat/cycle when both sides are ready.
- Counts are registered. They reflect all handshakes up to and including the last edge.
- The tready/tvalid paths must contain no combinational path from the same-side inputs.

## Structure

- Package `axis_pkg`:
  - typedef of the beat struct (tdata, tkeep, tlast, tuser), parametrised via module localparams.
  - helper function `clog2_cnt(depth)` returning the count width.
- Sub-module `axis_sdp_ram`: simple dual-port array, DEPTH x beat width, synchronous write, asynchronous read. It maps to distributed RAM.
- The top level holds the pointers, counters, full/empty logic and packet gating.

## Test plan

- Reset and fill, DEPTH=16, PACKET_MODE=0:
  - Release reset and check tready=0 in the first cycle and 1 in the next.
  - Write 16 beats with m_tready=0: count reaches 16, tready=0, m_tvalid=1.
- Streaming, PACKET_MODE=0: 100 random beats with both sides always ready:
  - output matches input, including tkeep and tuser.
  - count ≤ 1 throughout.
  - 1 beat/cycle after the first.
- Random back-pressure: 10% s_tvalid gaps and 30% m_tready gaps over 5000 beats:
  - scoreboard matches.
  - count never exceeds 16 and never underflows.
- Packet gating, PACKET_MODE=1:
  - Write a 5-beat frame with one idle cycle before tlast: m_tvalid stays 0 until the cycle after tlast is accepted, and pkt_count=1.
  - Drain the frame: pkt_count returns to 0.
- Oversize frame, PACKET_MODE=1, DEPTH=16: send a 20-beat frame; m_tvalid rises when count=16 and all 20 beats come out in order.
- Mid-operation reset: assert reset asynchronously with 7 beats stored; m_tvalid, tready and both counts go to 0 immediately, and the next frame passes cleanly.
